zbt_edge_arbiter: RTL

Shares the single 36-bit ZBT frame buffer between camera pixel-pair writes and display-side pixel-pair reads. The display read stream feeds the edge-detection datapath's `rgb`/`rgb1` inputs. Display reads own every even fetch slot in the active area; buffered camera writes drain in all other cycles. The block also expands 18-bit stored pixels (6:6:6) to 24-bit RGB and reports write overflow.

---
 rtl/edge_pkg.sv | 19 +
 rtl/zbt_wr_fifo.sv | 51 +++++
 rtl/zbt_edge_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared constants, write-entry type and pixel expansion for the ZBT edge arbiter
package edge_pkg;

    localparam int H_ACTIVE    = 1024;
    localparam int V_ACTIVE    = 768;
    localparam int FETCH_AHEAD = 4;
    localparam int ZBT_LAT     = 2;

    typedef struct packed {
        logic [18:0] addr;
        logic [35:0] data;
    } wr_entry_t;

    // 6:6:6 -> 8:8:8; each channel's top two bits are replicated into the LSBs
    function automatic logic [23:0] expand18to24(input logic [17:0] p);
        return {p[17:12], p[17:16], p[11:6], p[11:10], p[5:0], p[5:4]};
    endfunction

endpackage

// File: rtl/zbt_wr_fifo.sv
// rtl/zbt_wr_fifo.sv - synchronous FIFO buffering camera writes for the ZBT arbiter
//
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   i_push, i_push_entry: enqueue one entry (caller guarantees !o_full or i_pop)
//   i_pop               : dequeue head (caller guarantees !o_empty)
//   o_head              : current head entry, valid when !o_empty
//   o_full, o_empty     : occupancy flags
module zbt_wr_fifo
    import edge_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      i_push,
    input  wr_entry_t i_push_entry,
    input  logic      i_pop,
    output wr_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    wr_entry_t      r_mem [FIFO_DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers define what is valid
    always_ff @(posedge clock) begin
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_entry;
    end

endmodule

// File: rtl/zbt_edge_arbiter.sv
// rtl/zbt_edge_arbiter.sv - shares the ZBT frame buffer between display reads and buffered camera writes
//
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   hcount, vcount          : display raster position
//   cam_we/cam_addr/cam_data: camera pixel-pair write strobe, address, data {hi,lo}
//   mem_addr/mem_we/
//   mem_write_data          : ZBT address, write enable (active high), write data
//   mem_read_data           : ZBT read data, ZBT_LAT cycles after its address
//   pixel_lo/pixel_hi       : expanded 24-bit pixels of the returned pair
//   pair_valid              : one-cycle pulse when pixel_lo/pixel_hi update
//   overflow/drop_count     : sticky drop flag and saturating drop count
module zbt_edge_arbiter #(
    parameter int H_ACTIVE    = edge_pkg::H_ACTIVE,
    parameter int V_ACTIVE    = edge_pkg::V_ACTIVE,
    parameter int FETCH_AHEAD = edge_pkg::FETCH_AHEAD,
    parameter int FIFO_DEPTH  = 4,
    parameter int ZBT_LAT     = edge_pkg::ZBT_LAT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        cam_we,
    input  logic [18:0] cam_addr,
    input  logic [35:0] cam_data,
    output logic [18:0] mem_addr,
    output logic        mem_we,
    output logic [35:0] mem_write_data,
    input  logic [35:0] mem_read_data,
    output logic [23:0] pixel_lo,
    output logic [23:0] pixel_hi,
    output logic        pair_valid,
    output logic        overflow,
    output logic [15:0] drop_count
);

    import edge_pkg::*;

    logic [11:0]    w_fh;
    logic           w_rd_slot;
    logic           w_pop;
    logic           w_push;
    logic           w_drop;
    logic           w_full;
    logic           w_empty;
    wr_entry_t      w_head;
    wr_entry_t      w_push_entry;

    logic [18:0]    r_mem_addr;
    logic           r_mem_we;
    logic [35:0]    r_mem_write_data;
    logic [23:0]    r_pixel_lo;
    logic [23:0]    r_pixel_hi;
    logic           r_pair_valid;
    logic           r_overflow;
    logic [15:0]    r_drop_count;
    logic [ZBT_LAT:0] r_tag;

    // Reads take even lookahead positions inside the active area; the range
    // check on fh stops the lookahead from wrapping into the next line.
    assign w_fh      = {1'b0, hcount} + 12'(FETCH_AHEAD);
    assign w_rd_slot = ~w_fh[0] & (int'(w_fh) < H_ACTIVE) & (int'(vcount) < V_ACTIVE);

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    assign w_pop        = ~w_rd_slot & ~w_empty;
    assign w_push       = cam_we & (~w_full | w_pop);
    assign w_drop       = cam_we & ~w_push;
    assign w_push_entry = '{addr: cam_addr, data: cam_data};

    zbt_wr_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clock        (clock),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem_addr       <= '0;
            r_mem_we         <= 1'b0;
            r_mem_write_data <= '0;
            r_pixel_lo       <= '0;
            r_pixel_hi       <= '0;
            r_pair_valid     <= 1'b0;
            r_overflow       <= 1'b0;
            r_drop_count     <= '0;
            r_tag            <= '0;
        end else begin
            if (w_rd_slot) begin
                r_mem_addr <= {vcount, w_fh[9:1]};
                r_mem_we   <= 1'b0;
            end else if (w_pop) begin
                r_mem_addr       <= w_head.addr;
                r_mem_write_data <= w_head.data;
                r_mem_we         <= 1'b1;
            end else begin
                r_mem_we <= 1'b0;
            end

            // Tag leaves the top the cycle the matching read data is valid
            r_tag        <= {r_tag[ZBT_LAT-1:0], w_rd_slot};
            r_pair_valid <= r_tag[ZBT_LAT];
            if (r_tag[ZBT_LAT]) begin
                r_pixel_lo <= expand18to24(mem_read_data[17:0]);
                r_pixel_hi <= expand18to24(mem_read_data[35:18]);
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign mem_addr       = r_mem_addr;
    assign mem_we         = r_mem_we;
    assign mem_write_data = r_mem_write_data;
    assign pixel_lo       = r_pixel_lo;
    assign pixel_hi       = r_pixel_hi;
    assign pair_valid     = r_pair_valid;
    assign overflow       = r_overflow;
    assign drop_count     = r_drop_count;

endmodule
